vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered syncs, blanking and frame pulses.
// Optional macro VGA_SYNC_DELAY_EN adds one register stage on hs/vs/blank to align with a registered RGB path.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          armed_q, armed_d;
  logic          h_wrap;
  logic          v_wrap;

  // Outputs are decoded from the next counter values so they register in step with DrawX/DrawY.
  always_comb begin
    h_wrap        = (h_q == H_LAST);
    v_wrap        = h_wrap && (v_q == V_LAST);
    h_d           = h_wrap ? '0 : h_q + 1'b1;
    v_d           = v_q;
    frame_count_d = frame_count_q;
    armed_d       = armed_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
    end
    // The wrap out of the reset position starts frame 0 and is not counted as a completed frame.
    if (v_wrap) begin
      armed_d = 1'b1;
      if (armed_q) begin
        frame_count_d = frame_count_q + 8'd1;
      end
    end
    hs_d          = !((h_d >= H_SYNC_LO) && (h_d <= H_SYNC_HI));
    vs_d          = !((v_d >= V_SYNC_LO) && (v_d <= V_SYNC_HI));
    blank_d       = (h_d < H_VIS_END) && (v_d < V_VIS_END);
    line_start_d  = (h_d == '0);
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      armed_q       <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      armed_q       <= armed_d;
    end
  end

  assign DrawX       = 10'(h_q);
  assign DrawY       = 10'(v_q);
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, hs_dly_d;
  logic vs_dly_q, vs_dly_d;
  logic blank_dly_q, blank_dly_d;

  always_comb begin
    hs_dly_d    = hs_q;
    vs_dly_d    = vs_q;
    blank_dly_d = blank_q;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_dly_q    <= 1'b1;
      vs_dly_q    <= 1'b1;
      blank_dly_q <= 1'b0;
    end else begin
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      blank_dly_q <= blank_dly_d;
    end
  end

  assign hs    = hs_dly_q;
  assign vs    = vs_dly_q;
  assign blank = blank_dly_q;
`else
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: expected outputs derived from elapsed pixel count since reset release.
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       hs, vs, blank, line_start, frame_start;
  logic [9:0] DrawX, DrawY;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .hs(hs),
    .vs(vs),
    .blank(blank),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic blank;
    logic ls;
    logic fs;
    int   fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;
  logic prev_hs    = 1'b1;
  logic prev_vs    = 1'b1;
  logic prev_blank = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic r);
    exp_t e;
    logic rh, rv, rb;
    @(negedge vga_clk);
    reset = r;
    if (r) begin
      e.x = HT - 1; e.y = VT - 1; e.ls = 1'b0; e.fs = 1'b0; e.fc = 0;
      rh = 1'b1; rv = 1'b1; rb = 1'b0;
      t = 0;
`ifdef VGA_SYNC_DELAY_EN
      prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0;
`endif
    end else begin
      e.x  = t % HT;
      e.y  = (t / HT) % VT;
      e.fc = (t / FRAME) % 256;
      e.ls = (e.x == 0);
      e.fs = (e.x == 0) && (e.y == 0);
      rh = !(e.x >= HV + HF && e.x < HV + HF + HS);
      rv = !(e.y >= VV + VF && e.y < VV + VF + VS);
      rb = (e.x < HV) && (e.y < VV);
      t++;
    end
`ifdef VGA_SYNC_DELAY_EN
    e.hs = prev_hs; e.vs = prev_vs; e.blank = prev_blank;
    prev_hs = rh; prev_vs = rv; prev_blank = rb;
`else
    e.hs = rh; e.vs = rv; e.blank = rb;
`endif
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("DrawX",       32'(DrawX),       e.x);
        chk("DrawY",       32'(DrawY),       e.y);
        chk("hs",          32'(hs),          32'(e.hs));
        chk("vs",          32'(vs),          32'(e.vs));
        chk("blank",       32'(blank),       32'(e.blank));
        chk("line_start",  32'(line_start),  32'(e.ls));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("frame_count", 32'(frame_count), e.fc);
      end
    end
  end

  initial begin : driver
    hold_reset(3);
    run(2 * FRAME + 7);
    // reset landing exactly on the last pixel of a frame and on the first pixel of the next
    hold_reset(1);
    run(FRAME - 1);
    hold_reset(2);
    run(FRAME);
    hold_reset(1);
    run(1);
    hold_reset(1);
    for (int k = 0; k < 8; k++) begin
      run($urandom_range(1, 3 * FRAME));
      hold_reset($urandom_range(1, 3));
    end
    // long uninterrupted stretch so frame_count wraps 255 -> 0
    run(258 * FRAME + $urandom_range(0, FRAME - 1));
    hold_reset(2);
    run($urandom_range(HT, 2 * FRAME));
    @(posedge vga_clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
